// File: rtl/rs_buffer_sched_if.sv
// Handshake and strobe bundle between the RS byte-buffer controller, the
// upstream encoder, the buffer strobes and the downstream modulator.
interface rs_buffer_sched_if;
   logic in_valid;
   logic in_ready;
   logic push;
   logic pop;
   logic byte_valid;
   logic byte_ready;
   logic last_byte;

   modport master (
      input  in_valid,
      input  byte_ready,
      output in_ready,
      output push,
      output pop,
      output byte_valid,
      output last_byte
   );

   modport slave (
      output in_valid,
      output byte_ready,
      input  in_ready,
      input  push,
      input  pop,
      input  byte_valid,
      input  last_byte
   );
endinterface

// File: rtl/rs_buffer_sched.sv
// Sequences the transmitter RS byte buffer: accepts encoder words, paces head-byte
// pops to the modulator with a programmable gap, and tracks occupancy and underruns.
module rs_buffer_sched #(
   parameter int unsigned  BYTES_PER_WORD = 8,
   parameter int unsigned  DEPTH_WORDS    = 4,
   parameter int unsigned  GAP_W          = 8,
   parameter int unsigned  CNT_W          = 16,
   localparam int unsigned WC_W           = $clog2(DEPTH_WORDS + 1),
   localparam int unsigned IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 flush,
   input  logic [GAP_W-1:0]     gap_cycles,
   rs_buffer_sched_if.master    bus,
   output logic [WC_W-1:0]      word_cnt,
   output logic [CNT_W-1:0]     underrun_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OFFER = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [GAP_W-1:0]   rearm_q, rearm_d;
   logic [WC_W-1:0]    word_cnt_d;
   logic [CNT_W-1:0]   underrun_d;
   logic               byte_valid_q, byte_valid_d;

   logic               in_ready_c, push_c, pop_c, retire_c, idx_last_c;
   logic               has_data_c, more_c, underrun_ev_c;

   // Handshake strobes derived from registers and same-cycle inputs
   assign idx_last_c = (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));
   assign in_ready_c = rst_n & ~flush & (word_cnt < WC_W'(DEPTH_WORDS));
   assign push_c     = bus.in_valid & in_ready_c;
   assign pop_c      = rst_n & ~flush & byte_valid_q & bus.byte_ready;
   assign retire_c   = pop_c & idx_last_c;
   assign has_data_c = (word_cnt != '0);

   assign bus.in_ready   = in_ready_c;
   assign bus.push       = push_c;
   assign bus.pop        = pop_c;
   assign bus.byte_valid = byte_valid_q;
   assign bus.last_byte  = byte_valid_q & idx_last_c;

   // Next-state, occupancy, pacing and underrun accounting
   always_comb begin
      state_d       = state_q;
      byte_idx_d    = byte_idx_q;
      gap_d         = gap_q;
      rearm_d       = (rearm_q != '0) ? rearm_q - GAP_W'(1) : '0;
      underrun_ev_c = 1'b0;
      word_cnt_d    = word_cnt + WC_W'(push_c) - WC_W'(retire_c);
      more_c        = (word_cnt_d != '0);

      if (pop_c) begin
         byte_idx_d = idx_last_c ? '0 : byte_idx_q + IDX_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (en) begin
               if (has_data_c) begin
                  state_d = S_OFFER;
               end else if (rearm_q == '0) begin
                  underrun_ev_c = 1'b1;
                  rearm_d       = gap_cycles;
               end
            end
         end
         S_OFFER: begin
            if (pop_c) begin
               if (gap_cycles != '0) begin
                  state_d = S_GAP;
                  gap_d   = gap_cycles;
               end else if (en && more_c) begin
                  state_d = S_OFFER;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - GAP_W'(1);
            if (gap_q <= GAP_W'(1)) begin
               gap_d = '0;
               if (en && has_data_c) begin
                  state_d = S_OFFER;
               end else begin
                  state_d = S_IDLE;
                  if (en && (rearm_q == '0)) begin
                     underrun_ev_c = 1'b1;
                     rearm_d       = gap_cycles;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Starvation pacing restarts fresh whenever enable drops or data flows again
      if (!en || (state_d == S_OFFER)) begin
         rearm_d = '0;
      end

      if (flush) begin
         state_d       = S_IDLE;
         byte_idx_d    = '0;
         gap_d         = '0;
         rearm_d       = '0;
         word_cnt_d    = '0;
         underrun_ev_c = 1'b0;
      end

      byte_valid_d = (state_d == S_OFFER);
      underrun_d   = (underrun_ev_c && (underrun_cnt != '1)) ? underrun_cnt + CNT_W'(1)
                                                             : underrun_cnt;
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         byte_idx_q   <= '0;
         gap_q        <= '0;
         rearm_q      <= '0;
         word_cnt     <= '0;
         underrun_cnt <= '0;
         byte_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         gap_q        <= gap_d;
         rearm_q      <= rearm_d;
         word_cnt     <= word_cnt_d;
         underrun_cnt <= underrun_d;
         byte_valid_q <= byte_valid_d;
      end
   end

endmodule

// File: tb/tb_rs_buffer_sched.sv
// Bench for rs_buffer_sched: pacing vector table, hand-written corner sequences,
// and a byte-level scoreboard of last_byte / occupancy / in_ready.
module tb_rs_buffer_sched;
   localparam int unsigned BPW   = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned GAP_W = 8;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned WC_W  = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             flush = 1'b0;
   logic [GAP_W-1:0] gap_cycles = '0;
   logic [WC_W-1:0]  word_cnt;
   logic [CNT_W-1:0] underrun_cnt;

   rs_buffer_sched_if bus ();

   rs_buffer_sched #(
      .BYTES_PER_WORD (BPW),
      .DEPTH_WORDS    (DEPTH),
      .GAP_W          (GAP_W),
      .CNT_W          (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .flush        (flush),
      .gap_cycles   (gap_cycles),
      .bus          (bus),
      .word_cnt     (word_cnt),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Scoreboard: each accepted word expects BPW pops, only the last flagged last_byte
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin : mon
         int wc_m;
         wc_m = (sb_q.size() + BPW - 1) / BPW;
         chk("sb_word_cnt", 32'(word_cnt), 32'(wc_m));
         chk("sb_in_ready", 32'(bus.in_ready), 32'(!flush && (wc_m < DEPTH)));
         if (bus.pop) begin
            if (sb_q.size() == 0) chk("sb_pop_empty", 32'd1, 32'd0);
            else chk("sb_last_byte", 32'(bus.last_byte), 32'(sb_q.pop_front()));
         end
         if (flush) sb_q.delete();
         if (bus.push) begin
            for (int i = 0; i < BPW; i++) sb_q.push_back(i == BPW - 1);
         end
      end
   end

   typedef struct {
      int gap;
      int words;
      int exp_pops;
      int exp_space;
   } vec_t;

   vec_t vecs[5];

   initial begin : wdog
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int pops, last_t, t, u0, u1, pushes, popped;
      bit found, seen;

      vecs[0] = '{gap: 0, words: 1, exp_pops: 8,  exp_space: 1};
      vecs[1] = '{gap: 3, words: 1, exp_pops: 8,  exp_space: 4};
      vecs[2] = '{gap: 0, words: 2, exp_pops: 16, exp_space: 1};
      vecs[3] = '{gap: 2, words: 2, exp_pops: 16, exp_space: 3};
      vecs[4] = '{gap: 1, words: 3, exp_pops: 24, exp_space: 2};

      bus.in_valid   = 1'b1;
      bus.byte_ready = 1'b1;
      repeat (2) cyc();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_push", 32'(bus.push), 32'd0);
      chk("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      chk("rst_underrun", 32'(underrun_cnt), 32'd0);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      smp();
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      cyc();

      // Pacing table: load with en low, then enable and measure handshake spacing
      for (int v = 0; v < 5; v++) begin
         gap_cycles     = GAP_W'(vecs[v].gap);
         en             = 1'b0;
         bus.byte_ready = 1'b1;
         bus.in_valid   = 1'b1;
         for (int w = 0; w < vecs[v].words; w++) begin
            smp();
            chk("tbl_push", 32'(bus.push), 32'd1);
            cyc();
         end
         bus.in_valid = 1'b0;
         en = 1'b1;
         u0 = int'(underrun_cnt);
         smp();
         chk("tbl_bv_idle", 32'(bus.byte_valid), 32'd0);
         pops = 0; last_t = 0; t = 0;
         while (pops < vecs[v].exp_pops && t < 200) begin
            cyc();
            t++;
            smp();
            if (bus.pop) begin
               pops++;
               if (pops == 1) chk("tbl_first_pop", 32'(t), 32'd1);
               else chk("tbl_spacing", 32'(t - last_t), 32'(vecs[v].exp_space));
               last_t = t;
            end
         end
         chk("tbl_pop_count", 32'(pops), 32'(vecs[v].exp_pops));
         cyc();
         en = 1'b0;
         repeat (vecs[v].gap + 2) cyc();
         smp();
         chk("tbl_end_bv", 32'(bus.byte_valid), 32'd0);
         chk("tbl_end_wc", 32'(word_cnt), 32'd0);
         chk("tbl_underrun", 32'(underrun_cnt), 32'(u0));
         cyc();
      end

      // Fill to capacity with en low
      gap_cycles = '0;
      bus.in_valid = 1'b1;
      pushes = 0;
      repeat (6) begin
         smp();
         if (bus.push) pushes++;
         cyc();
      end
      chk("fill_pushes", 32'(pushes), 32'd4);
      smp();
      chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
      chk("fill_word_cnt", 32'(word_cnt), 32'd4);
      chk("fill_no_pop", 32'(bus.pop), 32'd0);
      cyc();
      bus.in_valid = 1'b0;
      en = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         smp();
         if (bus.pop && bus.last_byte) found = 1'b1;
         else cyc();
      end
      chk("fill_retire_seen", 32'(found), 32'd1);
      cyc();
      smp();
      chk("fill_after_in_ready", 32'(bus.in_ready), 32'd1);
      chk("fill_after_wc", 32'(word_cnt), 32'd3);

      // Push timed onto the next retiring pop
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         cyc();
         bus.in_valid = bus.last_byte;
         smp();
         if (bus.in_valid) begin
            chk("simul_push", 32'(bus.push), 32'd1);
            chk("simul_pop", 32'(bus.pop), 32'd1);
            found = 1'b1;
         end
      end
      chk("simul_seen", 32'(found), 32'd1);
      cyc();
      bus.in_valid = 1'b0;
      smp();
      chk("simul_wc", 32'(word_cnt), 32'd3);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         smp();
         if (bus.pop && bus.last_byte && word_cnt == WC_W'(1)) found = 1'b1;
      end
      chk("drain_done", 32'(found), 32'd1);
      cyc();
      en = 1'b0;

      // Backpressure with en dropped mid-wait
      bus.byte_ready = 1'b0;
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      en = 1'b1;
      cyc();
      for (int i = 0; i < 10; i++) begin
         smp();
         chk("bp_bv_held", 32'(bus.byte_valid), 32'd1);
         chk("bp_no_pop", 32'(bus.pop), 32'd0);
         cyc();
         if (i == 4) en = 1'b0;
      end
      bus.byte_ready = 1'b1;
      smp();
      chk("bp_pop", 32'(bus.pop), 32'd1);
      cyc();
      bus.byte_ready = 1'b0;
      smp();
      chk("bp_idle", 32'(bus.byte_valid), 32'd0);

      // Second word, then pop four more bytes to reach byte_idx 5 with two words resident
      cyc();
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      en = 1'b1;
      bus.byte_ready = 1'b1;
      popped = 0;
      for (int k = 0; k < 50 && popped < 4; k++) begin
         smp();
         if (bus.pop) popped++;
         if (popped < 4) cyc();
      end
      cyc();
      bus.byte_ready = 1'b0;
      smp();
      chk("pre_flush_bv", 32'(bus.byte_valid), 32'd1);
      chk("pre_flush_wc", 32'(word_cnt), 32'd2);
      chk("pre_flush_last", 32'(bus.last_byte), 32'd0);
      u0 = int'(underrun_cnt);
      cyc();
      flush = 1'b1;
      bus.byte_ready = 1'b1;
      bus.in_valid = 1'b1;
      smp();
      chk("flush_pop", 32'(bus.pop), 32'd0);
      chk("flush_push", 32'(bus.push), 32'd0);
      cyc();
      flush = 1'b0;
      bus.byte_ready = 1'b0;
      bus.in_valid = 1'b0;
      en = 1'b0;
      smp();
      chk("flush_bv", 32'(bus.byte_valid), 32'd0);
      chk("flush_wc", 32'(word_cnt), 32'd0);
      chk("flush_underrun", 32'(underrun_cnt), 32'(u0));
      cyc();
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      en = 1'b1;
      bus.byte_ready = 1'b1;
      popped = 0;
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         smp();
         if (bus.pop) begin
            popped++;
            if (bus.last_byte) found = 1'b1;
         end
         if (!found) cyc();
      end
      chk("flush_idx_reset", 32'(popped), 32'd8);
      cyc();
      en = 1'b0;

      // Starvation with gap 1: one underrun per two cycles
      gap_cycles = GAP_W'(1);
      cyc();
      u0 = int'(underrun_cnt);
      en = 1'b1;
      repeat (20) cyc();
      smp();
      chk("starve_underrun", 32'(underrun_cnt), 32'(u0 + 10));
      cyc();
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      popped = 0; found = 1'b0; seen = 1'b0; u1 = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         smp();
         if (bus.byte_valid && !seen) begin
            seen = 1'b1;
            u1 = int'(underrun_cnt);
         end
         if (bus.pop) begin
            popped++;
            if (bus.last_byte) found = 1'b1;
         end
         if (!found) cyc();
      end
      cyc();
      en = 1'b0;
      smp();
      chk("starve_flow_pops", 32'(popped), 32'd8);
      chk("starve_stopped", 32'(underrun_cnt), 32'(u1));

      // Async reset in the middle of an offer
      gap_cycles = '0;
      cyc();
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      en = 1'b1;
      bus.byte_ready = 1'b0;
      cyc();
      smp();
      chk("rst2_offering", 32'(bus.byte_valid), 32'd1);
      cyc();
      #1;
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      bus.byte_ready = 1'b1;
      #1;
      chk("rst2_push", 32'(bus.push), 32'd0);
      chk("rst2_pop", 32'(bus.pop), 32'd0);
      chk("rst2_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst2_bv", 32'(bus.byte_valid), 32'd0);
      chk("rst2_last", 32'(bus.last_byte), 32'd0);
      chk("rst2_wc", 32'(word_cnt), 32'd0);
      chk("rst2_underrun", 32'(underrun_cnt), 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      bus.byte_ready = 1'b0;
      en = 1'b0;
      smp();
      chk("rst2_after_bv", 32'(bus.byte_valid), 32'd0);
      repeat (2) cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
